// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared state encoding, latency defaults and helpers for the softmax controller
package softmax_pkg;

    localparam int DEF_MAX_LEN  = 1024;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_EXPO_LAT = 3;
    localparam int DEF_ACC_LAT  = 2;
    localparam int DEF_RECI_LAT = 4;
    localparam int DEF_MULT_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_EXP        = 3'd1,
        ST_EXP_DRAIN  = 3'd2,
        ST_ACC_WAIT   = 3'd3,
        ST_RECI       = 3'd4,
        ST_MULT       = 3'd5,
        ST_MULT_DRAIN = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ctrl_delay_line.sv
// rtl/ctrl_delay_line.sv - fixed-depth valid+address shift register with asynchronous clear
module ctrl_delay_line #(
    parameter int DEPTH  = 3,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic              valid_sr [DEPTH];
    logic [ADDR_W-1:0] addr_sr  [DEPTH];

    // Shift every stage by one per cycle; reset empties the whole line so no stale write-back survives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_sr[i] <= 1'b0;
                addr_sr[i]  <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            addr_sr[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                addr_sr[i]  <= addr_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[DEPTH-1];
    assign out_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/softmax_seq_ctrl.sv
// rtl/softmax_seq_ctrl.sv - softmax datapath sequencer; optional cycle counter under SOFTMAX_CTRL_PERF_EN
module softmax_seq_ctrl
    import softmax_pkg::*;
#(
    parameter int MAX_LEN  = DEF_MAX_LEN,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int EXPO_LAT = DEF_EXPO_LAT,
    parameter int ACC_LAT  = DEF_ACC_LAT,
    parameter int RECI_LAT = DEF_RECI_LAT,
    parameter int MULT_LAT = DEF_MULT_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   vec_len,
    output logic              busy,
    output logic              done,
    output logic              len_err,
    output logic              ram1_en_b,
    output logic [ADDR_W-1:0] ram1_addr_b,
    output logic              ram2_en_a,
    output logic              ram2_wr_en_a,
    output logic [ADDR_W-1:0] ram2_addr_a,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              reci_start,
    output logic              ram2_en_b,
    output logic [ADDR_W-1:0] ram2_addr_b,
    output logic              ram3_enable_a,
    output logic              ram3_wr_en_a,
    output logic [ADDR_W-1:0] ram3_addr_a,
    output logic [31:0]       perf_cycles
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] EXPO_LAST = CNT_W'(EXPO_LAT - 1);
    localparam logic [CNT_W-1:0] ACC_LAST  = CNT_W'(ACC_LAT - 1);
    localparam logic [CNT_W-1:0] RECI_LAST = CNT_W'(RECI_LAT - 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LAT - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  len_q, len_n;

    logic              busy_n, done_n, len_err_n, acc_clr_n;
    logic              ram1_en_n, reci_start_n, ram2b_en_n;
    logic [ADDR_W-1:0] ram1_addr_n, ram2b_addr_n;

    logic              expo_valid, mult_valid;
    logic [ADDR_W-1:0] expo_addr, mult_addr;

    // Next state, phase counter and next output values; outputs lag the state by one registered cycle
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        len_n        = len_q;
        busy_n       = (state != ST_IDLE);
        done_n       = 1'b0;
        len_err_n    = 1'b0;
        acc_clr_n    = 1'b0;
        ram1_en_n    = 1'b0;
        ram1_addr_n  = '0;
        reci_start_n = 1'b0;
        ram2b_en_n   = 1'b0;
        ram2b_addr_n = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0 && vec_len <= MAX_LEN_C) begin
                        len_n     = vec_len;
                        cnt_n     = '0;
                        acc_clr_n = 1'b1;
                        state_n   = ST_EXP;
                    end else begin
                        len_err_n = 1'b1;
                    end
                end
            end
            ST_EXP: begin
                ram1_en_n   = 1'b1;
                ram1_addr_n = cnt[ADDR_W-1:0];
                if (cnt == len_q - CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = ST_EXP_DRAIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_EXP_DRAIN: begin
                if (cnt == EXPO_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_ACC_WAIT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_ACC_WAIT: begin
                if (cnt == ACC_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_RECI;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RECI: begin
                reci_start_n = (cnt == '0);
                if (cnt == RECI_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_MULT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_MULT: begin
                ram2b_en_n   = 1'b1;
                ram2b_addr_n = cnt[ADDR_W-1:0];
                if (cnt == len_q - CNT_W'(1)) begin
                    cnt_n   = '0;
                    state_n = ST_MULT_DRAIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_MULT_DRAIN: begin
                if (cnt == MULT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done_n  = 1'b1;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered control outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            len_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            len_err     <= 1'b0;
            acc_clr     <= 1'b0;
            ram1_en_b   <= 1'b0;
            ram1_addr_b <= '0;
            reci_start  <= 1'b0;
            ram2_en_b   <= 1'b0;
            ram2_addr_b <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            len_q       <= len_n;
            busy        <= busy_n;
            done        <= done_n;
            len_err     <= len_err_n;
            acc_clr     <= acc_clr_n;
            ram1_en_b   <= ram1_en_n;
            ram1_addr_b <= ram1_addr_n;
            reci_start  <= reci_start_n;
            ram2_en_b   <= ram2b_en_n;
            ram2_addr_b <= ram2b_addr_n;
        end
    end

    ctrl_delay_line #(.DEPTH(EXPO_LAT), .ADDR_W(ADDR_W)) u_expo_dl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ram1_en_b),
        .in_addr   (ram1_addr_b),
        .out_valid (expo_valid),
        .out_addr  (expo_addr)
    );

    ctrl_delay_line #(.DEPTH(MULT_LAT), .ADDR_W(ADDR_W)) u_mult_dl (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ram2_en_b),
        .in_addr   (ram2_addr_b),
        .out_valid (mult_valid),
        .out_addr  (mult_addr)
    );

    assign ram2_en_a     = expo_valid;
    assign ram2_wr_en_a  = expo_valid;
    assign acc_en        = expo_valid;
    assign ram2_addr_a   = expo_addr;
    assign ram3_enable_a = mult_valid;
    assign ram3_wr_en_a  = mult_valid;
    assign ram3_addr_a   = mult_addr;

`ifdef SOFTMAX_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_q;

    // Count cycles from acceptance (counted as 1) through the done cycle; snapshot when done is raised
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cnt <= '0;
            perf_q   <= '0;
        end else begin
            if (state == ST_IDLE) begin
                if (acc_clr_n) begin
                    perf_cnt <= 32'd1;
                end
            end else begin
                perf_cnt <= sat_inc32(perf_cnt);
            end
            if (state == ST_DONE) begin
                perf_q <= sat_inc32(perf_cnt);
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// tb/tb_softmax_seq_ctrl.sv - directed self-checking bench for softmax_seq_ctrl
module tb_softmax_seq_ctrl;

    localparam int AW   = 10;
    localparam int MAXL = 1024;
    localparam int E    = 3;
    localparam int A    = 2;
    localparam int R    = 4;
    localparam int M    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          start2 = 1'b0;
    logic [AW:0]   vec_len = '0;
    logic [AW:0]   vec_len2 = '0;

    logic          busy, done, len_err, ram1_en_b, ram2_en_a, ram2_wr_en_a, acc_clr, acc_en;
    logic          reci_start, ram2_en_b, ram3_enable_a, ram3_wr_en_a;
    logic [AW-1:0] ram1_addr_b, ram2_addr_a, ram2_addr_b, ram3_addr_a;
    logic [31:0]   perf_cycles;

    logic          busy2, done2, len_err2, ram1_en_b2, ram2_en_a2, ram2_wr_en_a2, acc_clr2, acc_en2;
    logic          reci_start2, ram2_en_b2, ram3_enable_a2, ram3_wr_en_a2;
    logic [AW-1:0] ram1_addr_b2, ram2_addr_a2, ram2_addr_b2, ram3_addr_a2;
    logic [31:0]   perf_cycles2;

    logic [51:0]   obs, obs2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    softmax_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .len_err(len_err),
        .ram1_en_b(ram1_en_b), .ram1_addr_b(ram1_addr_b),
        .ram2_en_a(ram2_en_a), .ram2_wr_en_a(ram2_wr_en_a), .ram2_addr_a(ram2_addr_a),
        .acc_clr(acc_clr), .acc_en(acc_en), .reci_start(reci_start),
        .ram2_en_b(ram2_en_b), .ram2_addr_b(ram2_addr_b),
        .ram3_enable_a(ram3_enable_a), .ram3_wr_en_a(ram3_wr_en_a), .ram3_addr_a(ram3_addr_a),
        .perf_cycles(perf_cycles)
    );

    softmax_seq_ctrl #(
        .MAX_LEN(16), .ADDR_W(AW), .EXPO_LAT(1), .ACC_LAT(1), .RECI_LAT(1), .MULT_LAT(1)
    ) dut2 (
        .clk(clk), .rst(rst), .start(start2), .vec_len(vec_len2),
        .busy(busy2), .done(done2), .len_err(len_err2),
        .ram1_en_b(ram1_en_b2), .ram1_addr_b(ram1_addr_b2),
        .ram2_en_a(ram2_en_a2), .ram2_wr_en_a(ram2_wr_en_a2), .ram2_addr_a(ram2_addr_a2),
        .acc_clr(acc_clr2), .acc_en(acc_en2), .reci_start(reci_start2),
        .ram2_en_b(ram2_en_b2), .ram2_addr_b(ram2_addr_b2),
        .ram3_enable_a(ram3_enable_a2), .ram3_wr_en_a(ram3_wr_en_a2), .ram3_addr_a(ram3_addr_a2),
        .perf_cycles(perf_cycles2)
    );

    assign obs  = {busy, done, len_err, acc_clr, ram1_en_b, ram1_addr_b,
                   ram2_en_a, ram2_wr_en_a, acc_en, ram2_addr_a, reci_start,
                   ram2_en_b, ram2_addr_b, ram3_enable_a, ram3_wr_en_a, ram3_addr_a};
    assign obs2 = {busy2, done2, len_err2, acc_clr2, ram1_en_b2, ram1_addr_b2,
                   ram2_en_a2, ram2_wr_en_a2, acc_en2, ram2_addr_a2, reci_start2,
                   ram2_en_b2, ram2_addr_b2, ram3_enable_a2, ram3_wr_en_a2, ram3_addr_a2};

    // Cycle of the done pulse, relative to the acceptance cycle
    function automatic int done_cycle(input int n, input int e, input int a, input int r, input int m);
        return n + e + a + 1 + r + n + m;
    endfunction

    // Expected output vector in cycle c of a run of length n, from the published timing table
    function automatic logic [51:0] exp_vec(input int c, input int n, input int e, input int a,
                                            input int r, input int m);
        int tr, tm, td;
        logic r1, w2, rs, rb, w3;
        logic [AW-1:0] a1, a2, ab, a3;
        tr = n + e + a + 1;
        tm = tr + r;
        td = tm + n + m;
        r1 = (c >= 1) && (c <= n);
        w2 = (c >= 1 + e) && (c <= n + e);
        rs = (c == tr);
        rb = (c >= tm) && (c <= tm + n - 1);
        w3 = (c >= tm + m) && (c <= tm + n - 1 + m);
        a1 = r1 ? AW'(c - 1) : '0;
        a2 = w2 ? AW'(c - 1 - e) : '0;
        ab = rb ? AW'(c - tm) : '0;
        a3 = w3 ? AW'(c - tm - m) : '0;
        return {(c >= 1) && (c <= td), c == td, 1'b0, c == 0, r1, a1,
                w2, w2, w2, a2, rs, rb, ab, w3, w3, a3};
    endfunction

    function automatic logic [31:0] exp_perf(input int td);
`ifdef SOFTMAX_CTRL_PERF_EN
        return 32'(td + 1);
`else
        return 32'd0 + 32'(td * 0);
`endif
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== 52'd0 || obs2 !== 52'd0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h/%h exp=0", obs, obs2);
        end
        n_cmp++;
        if (perf_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_perf got=%0d exp=0", perf_cycles);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal(input string tag);
        int td;
        logic [51:0] ev;
        td = done_cycle(5, E, A, R, M);
        start = 1'b1;
        vec_len = 11'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= td + 1; c++) begin
            ev = exp_vec(c, 5, E, A, R, M);
            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL %s c=%0d got=%h exp=%h", tag, c, obs, ev);
            end
            if (c == td) begin
                n_cmp++;
                if (perf_cycles !== exp_perf(td)) begin
                    n_err++;
                    $display("FAIL %s_perf got=%0d exp=%0d", tag, perf_cycles, exp_perf(td));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_len_err();
        int td;
        logic [51:0] ev;
        logic [AW:0] bad [2];
        bad[0] = 11'd0;
        bad[1] = 11'(MAXL + 1);
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            vec_len = bad[i];
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if ({len_err, busy, acc_clr} !== 3'b100) begin
                n_err++;
                $display("FAIL len_err_pulse n=%0d got=%b exp=100", bad[i], {len_err, busy, acc_clr});
            end
            @(negedge clk);
            n_cmp++;
            if ({len_err, busy, acc_clr} !== 3'b000) begin
                n_err++;
                $display("FAIL len_err_after n=%0d got=%b exp=000", bad[i], {len_err, busy, acc_clr});
            end
        end
        td = done_cycle(MAXL, E, A, R, M);
        start = 1'b1;
        vec_len = 11'(MAXL);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= td + 1; c++) begin
            ev = exp_vec(c, MAXL, E, A, R, M);
            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL max_len c=%0d got=%h exp=%h", c, obs, ev);
            end
            if (c == MAXL) begin
                n_cmp++;
                if (ram1_addr_b !== 10'd1023) begin
                    n_err++;
                    $display("FAIL max_len_last_addr got=%0d exp=1023", ram1_addr_b);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int td1, td2;
        logic [51:0] ev;
        td1 = done_cycle(3, E, A, R, M);
        td2 = done_cycle(2, E, A, R, M);
        start = 1'b1;
        vec_len = 11'd3;
        @(negedge clk);
        for (int c = 0; c <= td1; c++) begin
            if (c == 2) vec_len = 11'd2;
            ev = exp_vec(c, 3, E, A, R, M);
            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL b2b_run1 c=%0d got=%h exp=%h", c, obs, ev);
            end
            @(negedge clk);
        end
        start = 1'b0;
        for (int c = 0; c <= td2 + 1; c++) begin
            ev = exp_vec(c, 2, E, A, R, M);
            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL b2b_run2 c=%0d got=%h exp=%h", c, obs, ev);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_min_len();
        int td, w2n, w3n;
        logic [51:0] ev;
        td = done_cycle(1, E, A, R, M);
        w2n = 0;
        w3n = 0;
        start = 1'b1;
        vec_len = 11'd1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= td + 1; c++) begin
            ev = exp_vec(c, 1, E, A, R, M);
            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL min_len c=%0d got=%h exp=%h", c, obs, ev);
            end
            if (ram2_wr_en_a === 1'b1) w2n++;
            if (ram3_wr_en_a === 1'b1) w3n++;
            if (c == 15) begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_err++;
                    $display("FAIL min_len_done15 got=%b exp=1", done);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (w2n !== 1 || w3n !== 1) begin
            n_err++;
            $display("FAIL min_len_writes got=%0d/%0d exp=1/1", w2n, w3n);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [51:0] ev;
        start = 1'b1;
        vec_len = 11'd5;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            ev = exp_vec(c, 5, E, A, R, M);
            n_cmp++;
            if (obs !== ev) begin
                n_err++;
                $display("FAIL abort_pre c=%0d got=%h exp=%h", c, obs, ev);
            end
            if (c < 6) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 52'd0 || perf_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL abort_immediate got=%h perf=%0d exp=0", obs, perf_cycles);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== 52'd0) begin
                n_err++;
                $display("FAIL abort_quiet c=%0d got=%h exp=0", c, obs);
            end
        end
        test_nominal("after_abort");
    endtask

    task automatic test_latency_sweep();
        int td;
        logic [51:0] ev;
        td = done_cycle(4, 1, 1, 1, 1);
        start2 = 1'b1;
        vec_len2 = 11'd4;
        @(negedge clk);
        start2 = 1'b0;
        for (int c = 0; c <= td + 1; c++) begin
            ev = exp_vec(c, 4, 1, 1, 1, 1);
            n_cmp++;
            if (obs2 !== ev) begin
                n_err++;
                $display("FAIL lat_sweep c=%0d got=%h exp=%h", c, obs2, ev);
            end
            if (c == 13) begin
                n_cmp++;
                if (done2 !== 1'b1) begin
                    n_err++;
                    $display("FAIL lat_sweep_done13 got=%b exp=1", done2);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_nominal("nominal");
        test_len_err();
        test_back_to_back();
        test_min_len();
        test_reset_mid_run();
        test_latency_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/softmax_seq_ctrl.md
# softmax_seq_ctrl

Parametrised sequencing controller for the pipelined softmax datapath; next generation of the fixed-length control unit. Drives RAM1 read, exponent-to-RAM2 write, accumulate, reciprocal and multiply-to-RAM3 write phases for a runtime-selected vector length. Operator latencies are compile-time parameters counted internally, so no external latency-done inputs are needed. Start/done handshake supports back-to-back vectors.

## Interface
- `MAX_LEN`, 1024: largest supported vector length.
- `ADDR_W`, 10: RAM address width; `MAX_LEN` ≤ 2^`ADDR_W`.
- `EXPO_LAT`, 3: RAM1 read plus exponent latency in cycles, ≥1.
- `ACC_LAT`, 2: accumulator settle cycles after the last `acc_en`, ≥1.
- `RECI_LAT`, 4: reciprocal latency in cycles, ≥1.
- `MULT_LAT`, 3: RAM2 read plus multiplier latency in cycles, ≥1.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request a run; sampled only in IDLE.
- `vec_len` in `ADDR_W`+1: element count N; sampled with `start`.
- `busy` out 1: high from the cycle after acceptance through the `done` cycle.
- `done` out 1: one-cycle pulse at run end.
- `len_err` out 1: one-cycle pulse when `start` is rejected.
- `ram1_en_b` out 1: RAM1 port B read enable.
- `ram1_addr_b` out `ADDR_W`: RAM1 port B read address.
- `ram2_en_a` out 1: RAM2 port A enable.
- `ram2_wr_en_a` out 1: RAM2 port A write enable.
- `ram2_addr_a` out `ADDR_W`: RAM2 port A address.
- `acc_clr` out 1: accumulator clear pulse.
- `acc_en` out 1: accumulate the current exponent.
- `reci_start` out 1: reciprocal launch pulse.
- `ram2_en_b` out 1: RAM2 port B read enable.
- `ram2_addr_b` out `ADDR_W`: RAM2 port B read address.
- `ram3_enable_a` out 1: RAM3 port A enable.
- `ram3_wr_en_a` out 1: RAM3 port A write enable.
- `ram3_addr_a` out `ADDR_W`: RAM3 port A address.
- `perf_cycles` out 32: cycle count of the last completed run.

## Operation
- States: IDLE → EXP → EXP_DRAIN → ACC_WAIT → RECI → MULT → MULT_DRAIN → DONE → IDLE.
- IDLE, `start`=1, N in 1..`MAX_LEN`: latch N, pulse `acc_clr`, go to EXP.
- IDLE, `start`=1, N=0 or N>`MAX_LEN`: pulse `len_err`, stay in IDLE.
- `start` outside IDLE is ignored, including in the DONE cycle.
- EXP: N cycles. `ram1_en_b`=1, `ram1_addr_b`=0..N-1, one address per cycle.
- Exponent write-back: each issue at address k produces, exactly `EXPO_LAT` cycles later, `ram2_en_a`=`ram2_wr_en_a`=`acc_en`=1 with `ram2_addr_a`=k.
- EXP_DRAIN: `EXPO_LAT` cycles. ACC_WAIT: `ACC_LAT` cycles.
- RECI: `RECI_LAT` cycles; `reci_start` is high in the first of them only.
- MULT: N cycles. `ram2_en_b`=1, `ram2_addr_b`=0..N-1.
- Multiply write-back: each read at address k produces, exactly `MULT_LAT` cycles later, `ram3_enable_a`=`ram3_wr_en_a`=1 with `ram3_addr_a`=k.
- MULT_DRAIN: `MULT_LAT` cycles. DONE: `done`=1 for one cycle.
- Internal counters are `ADDR_W`+1 bits wide. Addresses never wrap: the last address is N-1, including N=2^`ADDR_W` when `MAX_LEN` allows it.
- Reset, including mid-run: state goes to IDLE, all delay-line contents are cleared, and every output goes to 0. No write-back from the aborted run may appear after reset.

## Timing
- Reference point: cycle 0 is the cycle in which `start` is accepted; `acc_clr` is high in cycle 0.
- RAM1 reads in cycles 1..N.
- RAM2 writes in cycles 1+`EXPO_LAT`..N+`EXPO_LAT`.
- `reci_start` in cycle Tr = N+`EXPO_LAT`+`ACC_LAT`+1.
- RAM2 port B reads in cycles Tm..Tm+N-1, where Tm = Tr+`RECI_LAT`.
- RAM3 writes end in cycle Tm+N-1+`MULT_LAT`.
- `done` in cycle Tm+N+`MULT_LAT`.
- The earliest next acceptance is in the cycle after `done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SOFTMAX_CTRL_PERF_EN` defined: a 32-bit counter runs from cycle 0 to the `done` cycle. Its value, cycle 0 through `done` inclusive, is copied to `perf_cycles` at `done` and held. The counter saturates at all-ones.
- `SOFTMAX_CTRL_PERF_EN` undefined: `perf_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `softmax_pkg` holds the state encoding constants and the latency-parameter defaults.
- One sub-module, `ctrl_delay_line`: a parametrised-depth shift register carrying a valid bit plus an `ADDR_W` address, with asynchronous clear.
- It is instantiated twice, with depth `EXPO_LAT` and depth `MULT_LAT`.

## Test plan
- Nominal run, N=5 with default latencies: RAM1 reads in cycles 1–5; RAM2 writes to addresses 0–4 in cycles 4–8; `reci_start` in cycle 11; RAM2 port B reads in cycles 15–19; RAM3 writes in cycles 18–22; `done` in cycle 23; `perf_cycles`=24 with the macro defined.
- Length errors: N=0 gives a `len_err` pulse with `busy` staying 0. N=`MAX_LEN`+1 gives the same. N=`MAX_LEN` completes with a last address of `MAX_LEN`-1.
- Back-to-back runs: `start` held high continuously re-accepts in the cycle after `done`. `start` during a run is ignored, and its addresses and `done` timing are unchanged.
- Minimum length, N=1: exactly one write each to RAM2 and RAM3, both at address 0; `done` in cycle 2+12+1=15.
- Reset mid-run: asserting `rst` low in cycle 6 of an N=5 run forces all outputs to 0 immediately. After release, nothing is written; a fresh run then times exactly as in the nominal case.
- Latency sweep: with `EXPO_LAT`=`MULT_LAT`=1 and `ACC_LAT`=`RECI_LAT`=1, N=4 gives `done` at 2·4+4+1=13.
